// File: rtl/cache_write_arbiter_if.sv
// Bundle between the per-port input controllers, the write arbiter and the cache write side.
// valid/ready: a cell on port i moves on a rising edge only when in_vld[i] and in_rdy[i] are both high.
// The forwarded stream (out_vld) is push-only; out_rdy is sampled by the arbiter before it accepts.
interface cache_write_arbiter_if #(
  parameter int NUM_PORTS    = 16,
  parameter int PORT_NUM_BIT = 4,
  parameter int PRI_NUM_BIT  = 3,
  parameter int DATA_BIT     = 73
);
  logic [NUM_PORTS-1:0]             in_req;
  logic [NUM_PORTS*PRI_NUM_BIT-1:0] in_pri;
  logic [NUM_PORTS-1:0]             in_vld;
  logic [NUM_PORTS-1:0]             in_last;
  logic [NUM_PORTS*DATA_BIT-1:0]    in_data;
  logic [NUM_PORTS-1:0]             in_rdy;
  logic                             out_rdy;
  logic                             cache_afull;
  logic [NUM_PORTS-1:0]             gnt;
  logic                             out_vld;
  logic [DATA_BIT-1:0]              out_data;
  logic                             out_last;
  logic [PORT_NUM_BIT-1:0]          out_src;
  logic                             busy;
  logic                             err_timeout;
  logic                             dbg_state;

  modport master (
    output in_req, in_pri, in_vld, in_last, in_data, out_rdy, cache_afull,
    input  in_rdy, gnt, out_vld, out_data, out_last, out_src, busy, err_timeout, dbg_state
  );

  modport slave (
    input  in_req, in_pri, in_vld, in_last, in_data, out_rdy, cache_afull,
    output in_rdy, gnt, out_vld, out_data, out_last, out_src, busy, err_timeout, dbg_state
  );
endinterface

// File: rtl/cache_write_arbiter.sv
// Packet-level arbiter for the shared cache write port: strict priority, round-robin among
// equal priorities, grant held for a whole packet, cells forwarded with one cycle of latency.
module cache_write_arbiter #(
  parameter int NUM_PORTS    = 16,
  parameter int PORT_NUM_BIT = 4,
  parameter int PRI_NUM_BIT  = 3,
  parameter int DATA_BIT     = 73,
  parameter int TIMEOUT      = 255
) (
  input logic                  clk,
  input logic                  rst_n,
  cache_write_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [PORT_NUM_BIT:0] NP = (PORT_NUM_BIT + 1)'(NUM_PORTS);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t                  state;
  logic [NUM_PORTS-1:0]    gnt_q;
  logic [PORT_NUM_BIT-1:0] cur;
  logic [PORT_NUM_BIT-1:0] rr_ptr;
  logic [CNT_W-1:0]        idle_cnt;
  logic                    out_vld_q;
  logic [DATA_BIT-1:0]     out_data_q;
  logic                    out_last_q;
  logic [PORT_NUM_BIT-1:0] out_src_q;
  logic                    err_q;

  logic [PRI_NUM_BIT-1:0]  pri_a [NUM_PORTS];
  logic [DATA_BIT-1:0]     data_a [NUM_PORTS];
  logic [PRI_NUM_BIT-1:0]  max_pri;
  logic [PORT_NUM_BIT-1:0] win;
  logic                    found;
  logic [PORT_NUM_BIT:0]   scan_sum;
  logic [PORT_NUM_BIT-1:0] scan_idx;
  logic                    accept;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign pri_a[g]  = bus.in_pri[g*PRI_NUM_BIT +: PRI_NUM_BIT];
    assign data_a[g] = bus.in_data[g*DATA_BIT +: DATA_BIT];
  end

  // Highest requesting priority first, then the first matching port after the last winner.
  always_comb begin
    max_pri  = '0;
    win      = rr_ptr;
    found    = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (bus.in_req[i] && (pri_a[i] > max_pri)) max_pri = pri_a[i];
    end
    for (int k = 1; k <= NUM_PORTS; k++) begin
      scan_sum = {1'b0, rr_ptr} + (PORT_NUM_BIT + 1)'(k);
      if (scan_sum >= NP) scan_sum = scan_sum - NP;
      scan_idx = scan_sum[PORT_NUM_BIT-1:0];
      if (!found && bus.in_req[scan_idx] && (pri_a[scan_idx] == max_pri)) begin
        win   = scan_idx;
        found = 1'b1;
      end
    end
  end

  assign accept = (state == XFER) && bus.in_vld[cur] && bus.out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt_q      <= '0;
      cur        <= '0;
      rr_ptr     <= PORT_NUM_BIT'(NUM_PORTS - 1);
      idle_cnt   <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_src_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      out_vld_q <= 1'b0;
      err_q     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!bus.cache_afull && (bus.in_req != '0)) begin
            gnt_q    <= NUM_PORTS'(1) << win;
            cur      <= win;
            rr_ptr   <= win;
            idle_cnt <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            out_vld_q  <= 1'b1;
            out_data_q <= data_a[cur];
            out_last_q <= bus.in_last[cur];
            out_src_q  <= cur;
            idle_cnt   <= '0;
            if (bus.in_last[cur]) begin
              gnt_q <= '0;
              state <= IDLE;
            end
          end else if (!bus.in_vld[cur] && bus.out_rdy) begin
            // Stalls caused by the cache side are not the source's fault, so only these count.
            if (idle_cnt == CNT_LAST) begin
              gnt_q    <= '0;
              state    <= IDLE;
              err_q    <= 1'b1;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_rdy      = gnt_q & {NUM_PORTS{bus.out_rdy}};
  assign bus.gnt         = gnt_q;
  assign bus.out_vld     = out_vld_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_last    = out_last_q;
  assign bus.out_src     = out_src_q;
  assign bus.busy        = (state == XFER);
  assign bus.err_timeout = err_q;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_cache_write_arbiter.sv
// Randomized bench for cache_write_arbiter: per-port packet sources, a transaction-level
// arbitration model and an expected-cell queue compared against the forwarded stream.
module tb_cache_write_arbiter;

  localparam int N  = 16;
  localparam int PB = 4;
  localparam int P  = 3;
  localparam int D  = 73;
  localparam int TO = 255;
  localparam int W  = D + PB + 1;

  logic clk;
  logic rst_n;

  cache_write_arbiter_if #(.NUM_PORTS(N), .PORT_NUM_BIT(PB), .PRI_NUM_BIT(P), .DATA_BIT(D)) bus ();

  cache_write_arbiter #(
    .NUM_PORTS(N), .PORT_NUM_BIT(PB), .PRI_NUM_BIT(P), .DATA_BIT(D), .TIMEOUT(TO)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- stimulus knobs and sources ----------------
  int start_prob = 0;
  int vld_prob   = 80;
  int rdy_prob   = 70;
  int afull_prob = 0;
  int pri_max    = 7;
  bit stall      = 1'b0;

  bit             has_pkt [N];
  int             rem     [N];
  logic [P-1:0]   pri_s   [N];
  logic [D-1:0]   cur_d   [N];

  // ---------------- reference model ----------------
  int           m_gnt;
  int           m_rr;
  int           m_idle;
  logic         e_vld;
  logic         e_err;
  bit           seen_err;
  logic [N-1:0] accepted;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_gnt    = -1;
      m_rr     = N - 1;
      m_idle   = 0;
      e_vld    = 1'b0;
      e_err    = 1'b0;
      accepted = '0;
      exp_q.delete();
    end else begin
      e_vld = 1'b0;
      e_err = 1'b0;
      if (m_gnt < 0) begin
        if (!bus.cache_afull && (bus.in_req != '0)) begin
          int maxp;
          maxp = -1;
          for (int i = 0; i < N; i++)
            if (bus.in_req[i] && int'(bus.in_pri[i*P +: P]) > maxp) maxp = int'(bus.in_pri[i*P +: P]);
          for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_rr + k) % N;
            if (bus.in_req[idx] && int'(bus.in_pri[idx*P +: P]) == maxp) begin
              m_gnt = idx;
              break;
            end
          end
          m_rr   = m_gnt;
          m_idle = 0;
        end
      end else if (bus.out_rdy) begin
        if (bus.in_vld[m_gnt]) begin
          e_vld = 1'b1;
          accepted[m_gnt] = 1'b1;
          exp_q.push_back({bus.in_last[m_gnt], PB'(m_gnt), bus.in_data[m_gnt*D +: D]});
          m_idle = 0;
          if (bus.in_last[m_gnt]) m_gnt = -1;
        end else begin
          m_idle++;
          if (m_idle == TO) begin
            m_gnt    = -1;
            m_idle   = 0;
            e_err    = 1'b1;
            seen_err = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic new_cell(input int p);
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    cur_d[p] = r[D-1:0];
  endtask

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      if (accepted[p]) begin
        accepted[p] = 1'b0;
        rem[p]--;
        new_cell(p);
        if (rem[p] == 0) has_pkt[p] = 1'b0;
      end
      if (!has_pkt[p] && $urandom_range(99, 0) < start_prob) begin
        has_pkt[p] = 1'b1;
        rem[p]     = $urandom_range(6, 1);
        pri_s[p]   = P'($urandom_range(pri_max, 0));
        new_cell(p);
      end
      bus.in_req[p]          = has_pkt[p];
      bus.in_pri[p*P +: P]   = pri_s[p];
      bus.in_vld[p]          = has_pkt[p] && !stall && ($urandom_range(99, 0) < vld_prob);
      bus.in_last[p]         = (rem[p] == 1);
      bus.in_data[p*D +: D]  = cur_d[p];
    end
    bus.out_rdy     = ($urandom_range(99, 0) < rdy_prob);
    bus.cache_afull = ($urandom_range(99, 0) < afull_prob);
  endtask

  // ---------------- scoreboard / per-cycle checks ----------------
  task automatic check_cycle();
    logic [N-1:0] exp_gnt;
    logic [W-1:0] exp_cell;
    exp_gnt = (m_gnt < 0) ? '0 : (N'(1) << m_gnt);
    check("gnt", 128'(bus.gnt), 128'(exp_gnt));
    check("busy", 128'(bus.busy), 128'(m_gnt >= 0));
    check("err_timeout", 128'(bus.err_timeout), 128'(e_err));
    check("out_vld", 128'(bus.out_vld), 128'(e_vld));
    check("in_rdy", 128'(bus.in_rdy), 128'(exp_gnt & {N{bus.out_rdy}}));
    if (bus.out_vld && exp_q.size() != 0) begin
      exp_cell = exp_q.pop_front();
      check("out_cell", 128'({bus.out_last, bus.out_src, bus.out_data}), 128'(exp_cell));
    end
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check_cycle();
      drive();
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst_n           = 1'b0;
    seen_err        = 1'b0;
    bus.in_req      = '0;
    bus.in_pri      = '0;
    bus.in_vld      = '0;
    bus.in_last     = '0;
    bus.in_data     = '0;
    bus.out_rdy     = 1'b0;
    bus.cache_afull = 1'b0;
    for (int p = 0; p < N; p++) begin
      has_pkt[p] = 1'b0;
      rem[p]     = 0;
      pri_s[p]   = '0;
      cur_d[p]   = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Quiet bus after reset: nothing may be granted or forwarded.
    run_cycles(20);

    // Mixed priorities with backpressure and occasional almost-full.
    start_prob = 10; afull_prob = 5;
    run_cycles(3000);

    // All sources go silent while holding requests: the grant must be revoked.
    start_prob = 100; afull_prob = 0; rdy_prob = 90; stall = 1'b1; seen_err = 1'b0;
    for (int c = 0; c < 2000 && !seen_err; c++) run_cycles(1);
    check("timeout_seen", 128'(seen_err), 128'(1));
    run_cycles(3);
    stall = 1'b0; rdy_prob = 70; start_prob = 10;
    run_cycles(200);

    // Cache almost full for a long stretch: running packet completes, then no new grants.
    afull_prob = 100;
    run_cycles(200);
    afull_prob = 5;
    run_cycles(300);

    // Asynchronous reset in the middle of a packet.
    for (int c = 0; c < 500 && m_gnt < 0; c++) run_cycles(1);
    check("grant_before_reset", 128'(m_gnt >= 0), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_gnt", 128'(bus.gnt), 128'(0));
    check("async_rst_out_vld", 128'(bus.out_vld), 128'(0));
    check("async_rst_busy", 128'(bus.busy), 128'(0));
    check("async_rst_in_rdy", 128'(bus.in_rdy), 128'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive();

    // Equal priorities everywhere to exercise the round-robin rotation.
    pri_max = 0; start_prob = 20; afull_prob = 0; rdy_prob = 85;
    run_cycles(2000);

    // Drain and make sure every predicted cell came out.
    start_prob = 0; vld_prob = 100; rdy_prob = 100;
    run_cycles(100);
    check("exp_q_drained", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_write_arbiter.md
Name: cache_write_arbiter

Overview:
- Packet-level arbiter that shares the single shared-cache write port between NUM_PORTS input data controllers.
- Selects one requesting port at a time. Strict priority on the packet's priority field, round-robin among equal priorities.
- Holds the grant for the whole packet and forwards its cells, registered, to the cache write logic.
- Sits between the per-port input controllers and the shared cache write-address/storage manager.

Parameters:
NUM_PORTS, 16, number of input controllers arbitrated
PORT_NUM_BIT, 4, width of source-port index (log2 NUM_PORTS)
PRI_NUM_BIT, 3, priority field width; higher value = higher priority
DATA_BIT, 73, cell width forwarded to the cache
TIMEOUT, 255, max consecutive idle cycles allowed within a granted packet before the grant is revoked

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_req  in  NUM_PORTS  per-port request: a packet is waiting (level)
in_pri  in  NUM_PORTS*PRI_NUM_BIT  per-port packet priority, port i at [i*PRI_NUM_BIT +: PRI_NUM_BIT]; valid while in_req[i]
in_vld  in  NUM_PORTS  per-port cell valid
in_last  in  NUM_PORTS  per-port last-cell flag, qualified by in_vld
in_data  in  NUM_PORTS*DATA_BIT  per-port cell, port i at [i*DATA_BIT +: DATA_BIT]
in_rdy  out  NUM_PORTS  per-port cell accept, combinational: gnt[i] & out_rdy
out_rdy  in  1  cache write side can accept a cell this cycle
cache_afull  in  1  cache almost full; blocks new grants only
gnt  out  NUM_PORTS  one-hot grant, registered
out_vld  out  1  forwarded cell valid
out_data  out  DATA_BIT  forwarded cell
out_last  out  1  forwarded cell is last of packet
out_src  out  PORT_NUM_BIT  source port of forwarded cell
busy  out  1  high in XFER state
err_timeout  out  1  one-cycle pulse on grant revocation

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt=0, out_vld=0, out_data=0, out_last=0, out_src=0, busy=0, err_timeout=0, rr_ptr=NUM_PORTS-1, idle counter=0. Asserting reset mid-packet abandons the packet; no partial output after release.
- States: IDLE, XFER.
- IDLE, arbitration:
  - If cache_afull=0 and in_req!=0, compute a winner and on the next clock set gnt=onehot(winner), state=XFER.
  - Otherwise stay in IDLE, gnt=0.
  - Winner: maximum in_pri among requesting ports. Among ties, first index scanning cyclically from rr_ptr+1.
  - rr_ptr<=winner on grant.
- XFER:
  - Cell accepted when in_vld[w] & gnt[w] & out_rdy.
  - An accepted cell is registered: out_vld=1, out_data=in_data[w], out_last=in_last[w], out_src=w. Latency exactly 1 cycle.
  - Cycles with no accept drive out_vld=0. out_data holds its last value.
  - Accepted cell with in_last=1: gnt<=0 and state<=IDLE on the same edge. The earliest next grant is one cycle later, so the minimum inter-packet gap at gnt is 1 cycle.
  - in_req and in_pri changes are ignored during XFER. cache_afull is ignored during XFER; the packet always completes. Only out_rdy stalls.
  - in_vld/in_data of non-granted ports are ignored. in_rdy is 0 for non-granted ports.
- Timeout:
  - The idle counter increments each XFER cycle with in_vld[w]=0 and resets on any accept.
  - out_rdy=0 cycles do not count.
  - When the counter reaches TIMEOUT: gnt<=0, state<=IDLE, err_timeout pulses 1 cycle, and the counter clears. The packet is not terminated downstream; no out_last is emitted.
- A single requester re-wins immediately after its packet ends when no other port requests.

Test Plan:
- Reset release, no requests -> gnt=0, out_vld=0, busy=0 indefinitely; async rst_n=0 mid-packet clears gnt and out_vld without a clock edge.
- Ports 2,5,9 request with equal pri=3, 4-cell packets each, out_rdy=1 -> grants in order 2,5,9. out_src follows 2,2,2,2,5,…; out_last on every 4th cell; 1-cycle gap between packets.
- Port 1 pri=2 and port 7 pri=6 request together -> port 7 granted first. Port 12 raising pri=6 during port 7's packet does not preempt it. After port 7, port 12 (pri 6) is granted before port 1.
- Granted port 4, out_rdy toggles 1,0,1,0 across an 8-cell packet -> in_rdy[4] mirrors out_rdy, exactly 8 out_vld pulses, data order preserved, each 1 cycle after acceptance.
- cache_afull=1 with in_req=0x0003 -> no grant. During an active grant with afull rising, the packet finishes, then no new grant until afull=0.
- Granted port 3 stops in_vld after 2 cells, TIMEOUT=255 -> gnt[3] drops after 255 idle cycles, err_timeout one-cycle pulse, and the next requester is granted the cycle after.
